// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared types and constants for the data-memory arbiter
//
// Purpose : state encoding, port index constants and the read-latency counter
//           width used by dmem_arbiter and rr_arb2.
// Ports   : none (package).

package dmem_arb_pkg;

  // Sequencer states. IDLE and RESP are the only arbitration points.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Requester indices as seen by the arbiter select/pointer.
  localparam logic P_CPU = 1'b0;
  localparam logic P_LDR = 1'b1;

  // Read-latency down-counter width; covers RD_LAT values 1..7.
  localparam int CNT_W   = 3;
  localparam int LAT_MAX = (1 << CNT_W) - 1;

  // True when a read latency fits the counter and is non-zero.
  function automatic bit lat_ok(input int lat);
    return (lat >= 1) && (lat <= LAT_MAX);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester and memory-side bundle for dmem_arbiter
//
// Purpose : groups both requester ports (p0 = CPU, p1 = loader/debug) and the
//           single data-memory port into one bundle.
// Modports:
//   slave  - arbiter side: takes requests, returns gnt/ack/rdata, drives memory
//   master - environment side: drives requests and memory read data

interface dmem_arb_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);

  // Port 0 (CPU)
  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_gnt;
  logic              p0_ack;
  logic [DATA_W-1:0] p0_rdata;

  // Port 1 (loader / debug)
  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_gnt;
  logic              p1_ack;
  logic [DATA_W-1:0] p1_rdata;

  // Shared data memory
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_write;
  logic              mem_read;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_gnt, p0_ack, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_gnt, p1_ack, p1_rdata,
    output mem_addr, mem_wdata, mem_write, mem_read,
    input  mem_rdata
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_gnt, p0_ack, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_gnt, p1_ack, p1_rdata,
    input  mem_addr, mem_wdata, mem_write, mem_read,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// rtl/dmem_arbiter_rr_arb2.sv - two-way arbiter with last-grant pointer
//
// Purpose : picks one of two requesters. A lone requester always wins. On a
//           tie, fixed-priority mode picks port 0; round-robin mode picks the
//           port that was not granted last.
// Ports   :
//   clk      in   clock
//   reset_n  in   asynchronous active-low reset (pointer -> port 1)
//   req      in   [1:0] request vector, bit n = port n
//   take     in   the current sel is being granted; advance the pointer
//   sel      out  selected port index (valid when req != 0)

module rr_arb2
  import dmem_arb_pkg::*;
#(
  parameter int CPU_PRIORITY = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       take,
  output logic       sel
);

  // Port last granted. Reset value points at port 1 so port 0 wins the
  // first tie after reset.
  logic last;

  always_comb begin
    sel = P_CPU;
    if (req == 2'b10) begin
      sel = P_LDR;
    end else if ((req == 2'b11) && (CPU_PRIORITY == 0)) begin
      sel = ~last;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last <= P_LDR;
    end else if (take) begin
      last <= sel;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter/sequencer for the shared data memory
//
// Purpose : shares one data memory between the CPU (port 0) and the
//           loader/debug master (port 1). One access at a time: arbitrate,
//           issue the strobe, wait out the read latency, then acknowledge.
// Parameters:
//   ADDR_W, DATA_W  address / data width
//   RD_LAT          cycles from mem_read to valid mem_rdata (1..7)
//   CPU_PRIORITY    1 = port 0 always wins ties, 0 = round-robin
// Ports   :
//   clk      in   clock, all state on the rising edge
//   reset_n  in   asynchronous active-low reset
//   bus      --   dmem_arb_if.slave: p0_*/p1_* request ports and mem_* port
// Timing  : request sampled in cycle 0 -> gnt in cycle 1; write ack cycle 2;
//           read ack cycle 2+RD_LAT. All outputs are registered.

module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int RD_LAT       = 1,
  parameter int CPU_PRIORITY = 0
) (
  input  logic      clk,
  input  logic      reset_n,
  dmem_arb_if.slave bus
);

  generate
    if (!lat_ok(RD_LAT)) begin : g_bad_rd_lat
      $error("dmem_arbiter: RD_LAT must be in 1..7");
    end
  endgenerate

  state_t            state;
  logic              owner;     // port that owns the access in flight
  logic              l_we;      // latched direction of the access in flight
  logic [CNT_W-1:0]  cnt;       // WAIT cycles remaining minus one

  logic [1:0]        req;
  logic              sel;
  logic              take;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  assign req  = {bus.p1_req, bus.p0_req};
  // Requests are only looked at in IDLE and RESP; changes during
  // ISSUE/WAIT are ignored until the next arbitration point.
  assign take = ((state == ST_IDLE) || (state == ST_RESP)) && (req != 2'b00);

  always_comb begin
    win_we    = bus.p0_we;
    win_addr  = bus.p0_addr;
    win_wdata = bus.p0_wdata;
    if (sel == P_LDR) begin
      win_we    = bus.p1_we;
      win_addr  = bus.p1_addr;
      win_wdata = bus.p1_wdata;
    end
  end

  rr_arb2 #(
    .CPU_PRIORITY (CPU_PRIORITY)
  ) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .take    (take),
    .sel     (sel)
  );

  // Single sequencer process. Output registers are loaded on the edge that
  // enters the state they belong to, so every output is glitch-free and
  // lines up with the state it describes. mem_addr/mem_wdata double as the
  // latched winner address/data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      owner         <= P_CPU;
      l_we          <= 1'b0;
      cnt           <= '0;
      bus.p0_gnt    <= 1'b0;
      bus.p0_ack    <= 1'b0;
      bus.p0_rdata  <= '0;
      bus.p1_gnt    <= 1'b0;
      bus.p1_ack    <= 1'b0;
      bus.p1_rdata  <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_write <= 1'b0;
      bus.mem_read  <= 1'b0;
    end else begin
      // gnt and ack are single-cycle pulses
      bus.p0_gnt <= 1'b0;
      bus.p1_gnt <= 1'b0;
      bus.p0_ack <= 1'b0;
      bus.p1_ack <= 1'b0;

      case (state)
        ST_IDLE, ST_RESP: begin
          bus.mem_read  <= 1'b0;
          bus.mem_write <= 1'b0;
          if (take) begin
            state        <= ST_ISSUE;
            owner        <= sel;
            l_we         <= win_we;
            bus.mem_addr <= win_addr;
            if (sel == P_LDR) begin
              bus.p1_gnt <= 1'b1;
            end else begin
              bus.p0_gnt <= 1'b1;
            end
            if (win_we) begin
              bus.mem_write <= 1'b1;
              bus.mem_wdata <= win_wdata;
            end else begin
              bus.mem_read  <= 1'b1;
            end
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_ISSUE: begin
          if (l_we) begin
            // Write completes in its single strobe cycle.
            bus.mem_write <= 1'b0;
            state         <= ST_RESP;
            if (owner == P_LDR) begin
              bus.p1_ack <= 1'b1;
            end else begin
              bus.p0_ack <= 1'b1;
            end
          end else begin
            // mem_read stays high through WAIT; count RD_LAT cycles there.
            cnt   <= CNT_W'(RD_LAT - 1);
            state <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (cnt == '0) begin
            // Edge ending the last WAIT cycle: capture read data.
            bus.mem_read <= 1'b0;
            state        <= ST_RESP;
            if (owner == P_LDR) begin
              bus.p1_ack   <= 1'b1;
              bus.p1_rdata <= bus.mem_rdata;
            end else begin
              bus.p0_ack   <= 1'b1;
              bus.p0_rdata <= bus.mem_rdata;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        default: begin
          state         <= ST_IDLE;
          bus.mem_read  <= 1'b0;
          bus.mem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule
